// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
//
// Definitions shared by the CPU bus-side blocks (fetch, decode, RAM/IO bus).
//
// Contents:
//   PHASE_W       - width of the instruction-cycle phase counter
//   phase_e       - the eight phases of one instruction cycle (A1..X3)
//   fetch_state_e - fetch FSM states (FIRST / SECOND byte of an instruction)
//   is_two_byte() - opcode decode: does this opcode carry a second byte?
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int PHASE_W = 3;

    // One instruction cycle is eight clocks. The ROM keeps its own copy of
    // this counter, so the encoding must not change.
    //   A1/A2 : address nibbles out (low, then high)
    //   A3    : bus turnaround
    //   M1/M2 : ROM returns the byte (high, then low nibble)
    //   X1..X3: execute; X3 is the last clock before the next A1
    typedef enum logic [PHASE_W-1:0] {
        PH_A1 = 3'd0,
        PH_A2 = 3'd1,
        PH_A3 = 3'd2,
        PH_M1 = 3'd3,
        PH_M2 = 3'd4,
        PH_X1 = 3'd5,
        PH_X2 = 3'd6,
        PH_X3 = 3'd7
    } phase_e;

    // FIRST: the byte being fetched is an opcode.
    // SECOND: the byte being fetched is the operand of the previous opcode.
    typedef enum logic {
        FETCH_FIRST  = 1'b0,
        FETCH_SECOND = 1'b1
    } fetch_state_e;

    // Two-byte opcodes: high nibble 0x1, 0x4, 0x5, 0x7, or 0x2 with bit 0
    // clear (0x2 with bit 0 set is a single-byte register-pair op).
    function automatic logic is_two_byte(input logic [7:0] opcode);
        logic [3:0] hi;
        hi = opcode[7:4];
        return (hi == 4'h1) || (hi == 4'h4) || (hi == 4'h5) || (hi == 4'h7) ||
               ((hi == 4'h2) && !opcode[0]);
    endfunction

endpackage : cpu_pkg

// File: rtl/bus_timing.sv
// ----------------------------------------------------------------------------
// bus_timing
//
// Free-running 8-phase instruction-cycle counter for the multiplexed 4-bit
// bus, plus the sync strobe that tells bus slaves the next clock is A1.
// Shared by the fetch stage and the RAM/IO bus interfaces so every bus
// master sees an identical phase.
//
// Ports:
//   clock_i   - system clock, all state on the rising edge
//   reset_n_i - asynchronous active-low reset; phase returns to A1
//   phase_o   - current phase (A1..X3)
//   sync_o    - high during X3 only, decoded straight from the counter
// ----------------------------------------------------------------------------
module bus_timing
    import cpu_pkg::*;
(
    input  logic   clock_i,
    input  logic   reset_n_i,
    output phase_e phase_o,
    output logic   sync_o
);

    phase_e phase_q;
    phase_e phase_d;

    // Natural 3-bit wrap takes X3 (7) back to A1 (0).
    always_comb begin
        phase_d = phase_e'(phase_q + PHASE_W'(1));
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            phase_q <= PH_A1;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;
    assign sync_o  = (phase_q == PH_X3);

endmodule : bus_timing

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage on the shared 4-bit multiplexed ROM bus. Owns the
// program counter, drives the address nibbles in A1/A2, assembles the byte
// the ROM returns in M1/M2 and hands complete instructions to decode with a
// one-clock strobe in X1. Jumps and holds are sampled in X3 only.
//
// Build option:
//   FETCH_TWO_BYTE_EN - when defined, opcodes decoded by is_two_byte() pull
//                       a second byte into `operand` before `instr_valid`
//                       fires (with `two_byte`). When undefined every byte
//                       is a complete instruction, `operand`/`two_byte` are
//                       tied 0, and jump/hold are honoured in every X3.
//
// Ports:
//   clock       in   system clock
//   reset_n     in   asynchronous active-low reset
//   data        io   ROM bus; driven only in A1/A2 (pc low, then high nibble)
//   sync        out  high in X3, marks the next clock as A1
//   pc          out  address of the instruction cycle in progress
//   instr       out  last fetched opcode byte
//   operand     out  second byte of a two-byte instruction, 0 otherwise
//   instr_valid out  one-clock strobe in X1: instr/operand are complete
//   two_byte    out  qualifies instr_valid: operand is meaningful
//   hold        in   sampled in X3: refetch the same pc next cycle
//   jump_en     in   sampled in X3: next fetch address is jump_addr
//   jump_addr   in   jump target
// ----------------------------------------------------------------------------
module fetch_unit
    import cpu_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    inout  wire  [3:0] data,
    output logic       sync,
    output logic [7:0] pc,
    output logic [7:0] instr,
    output logic [7:0] operand,
    output logic       instr_valid,
    output logic       two_byte,
    input  logic       hold,
    input  logic       jump_en,
    input  logic [7:0] jump_addr
);

    // ------------------------------------------------------------------
    // Phase counter
    // ------------------------------------------------------------------
    phase_e phase;
    logic   bus_sync;

    bus_timing u_bus_timing (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .phase_o   (phase),
        .sync_o    (bus_sync)
    );

    assign sync = bus_sync;

    // ------------------------------------------------------------------
    // Fetch state
    // ------------------------------------------------------------------
    logic [7:0] pc_q;
    logic [7:0] pc_d;
    logic [7:0] instr_q;
    logic [3:0] cap_hi_q;
    logic       valid_q;
    logic [7:0] fetched_byte;
    logic       ctl_honoured;

`ifdef FETCH_TWO_BYTE_EN
    fetch_state_e state_q;
    logic [7:0]   operand_q;
    logic         two_byte_q;

    // While the operand byte is being fetched the pc must simply step to
    // the next byte, so jump/hold are ignored in SECOND.
    assign ctl_honoured = (state_q == FETCH_FIRST);
`else
    assign ctl_honoured = 1'b1;
`endif

    // The low nibble is still on the bus during M2, so the complete byte is
    // formed here and registered directly into instr/operand at the end of
    // M2; that puts the strobe in X1.
    assign fetched_byte = {cap_hi_q, data};

    // Next pc, applied at the end of X3. Priority: jump > hold > increment;
    // 8-bit arithmetic wraps 0xFF to 0x00.
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        pc_d = pc_q + 8'd1;
        if (ctl_honoured) begin
            if (jump_en) begin
                pc_d = jump_addr;
            end else if (hold) begin
                pc_d = pc_q;
            end
        end
    end

    // Reset clears any half-captured byte as well, so a fetch interrupted by
    // reset can never complete afterwards.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= 8'h00;
            instr_q    <= 8'h00;
            cap_hi_q   <= 4'h0;
            valid_q    <= 1'b0;
`ifdef FETCH_TWO_BYTE_EN
            state_q    <= FETCH_FIRST;
            operand_q  <= 8'h00;
            two_byte_q <= 1'b0;
`endif
        end else begin
            // Strobes are high for one clock only.
            valid_q    <= 1'b0;
`ifdef FETCH_TWO_BYTE_EN
            two_byte_q <= 1'b0;
`endif
            unique case (phase)
                PH_M1: begin
                    cap_hi_q <= data;
                end
                PH_M2: begin
`ifdef FETCH_TWO_BYTE_EN
                    if (state_q == FETCH_SECOND) begin
                        operand_q  <= fetched_byte;
                        valid_q    <= 1'b1;
                        two_byte_q <= 1'b1;
                        state_q    <= FETCH_FIRST;
                    end else begin
                        instr_q   <= fetched_byte;
                        operand_q <= 8'h00;
                        if (is_two_byte(fetched_byte)) begin
                            state_q <= FETCH_SECOND;
                        end else begin
                            valid_q <= 1'b1;
                        end
                    end
`else
                    instr_q <= fetched_byte;
                    valid_q <= 1'b1;
`endif
                end
                PH_X3: begin
                    pc_q <= pc_d;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus drive: pc nibbles in A1/A2, released otherwise. Gating with
    // reset_n releases the bus the instant reset asserts, even though the
    // counter already reads A1 while reset is held.
    // ------------------------------------------------------------------
    logic       drive_en;
    logic [3:0] drive_nib;

    assign drive_en  = reset_n && ((phase == PH_A1) || (phase == PH_A2));
    assign drive_nib = (phase == PH_A2) ? pc_q[7:4] : pc_q[3:0];
    assign data      = drive_en ? drive_nib : 4'bz;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
`ifdef FETCH_TWO_BYTE_EN
    assign operand     = operand_q;
    assign two_byte    = two_byte_q;
`else
    assign operand     = 8'h00;
    assign two_byte    = 1'b0;
`endif

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit against a behavioural ROM on the shared bus. Expected
// instructions (completion clock, pc, instr, operand, two_byte) are queued
// as each instruction cycle is started and compared by a monitor when
// instr_valid is due. The bus carries a pull-up so a released bus reads 0xF.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    logic       clock = 1'b0;
    logic       reset_n;
    tri1  [3:0] data;
    logic       sync;
    logic [7:0] pc;
    logic [7:0] instr;
    logic [7:0] operand;
    logic       instr_valid;
    logic       two_byte;
    logic       hold;
    logic       jump_en;
    logic [7:0] jump_addr;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    fetch_unit dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data        (data),
        .sync        (sync),
        .pc          (pc),
        .instr       (instr),
        .operand     (operand),
        .instr_valid (instr_valid),
        .two_byte    (two_byte),
        .hold        (hold),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr)
    );

    // ------------------------------------------------------------------
    // ROM model: own phase counter, reset by the same reset_n, latches the
    // address in A1/A2 and returns the byte high nibble first in M1/M2.
    // ------------------------------------------------------------------
    logic [7:0] mem [256];
    logic [2:0] rom_phase;
    logic [7:0] rom_addr;
    logic       rom_en;
    logic [3:0] rom_nib;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rom_phase <= 3'd0;
            rom_addr  <= 8'h00;
        end else begin
            if (rom_phase == 3'd0) rom_addr[3:0] <= data;
            if (rom_phase == 3'd1) rom_addr[7:4] <= data;
            rom_phase <= rom_phase + 3'd1;
        end
    end

    assign rom_en  = reset_n && ((rom_phase == 3'd3) || (rom_phase == 3'd4));
    assign rom_nib = (rom_phase == 3'd3) ? mem[rom_addr][7:4] : mem[rom_addr][3:0];
    assign data    = rom_en ? rom_nib : 4'bz;

    // Clock index since the last reset release; index 0 is the first A1.
    int cyc;
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h (clock %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int         cyc;
        logic [7:0] pc;
        logic [7:0] instr;
        logic [7:0] operand;
        logic       two_byte;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clock) begin
        if (reset_n) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                mon_e = sb.pop_front();
                check("valid_strobe", {7'd0, instr_valid}, 8'h01);
                check("valid_pc",     pc,                  mon_e.pc);
                check("valid_instr",  instr,               mon_e.instr);
                check("valid_operand", operand,            mon_e.operand);
                check("valid_two_byte", {7'd0, two_byte},  {7'd0, mon_e.two_byte});
            end else if (instr_valid) begin
                check("spurious_valid", {7'd0, instr_valid}, 8'h00);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    logic [7:0] exp_pc;

    // Called at the start of A1: the instruction at exp_pc completes in X1.
    task automatic push_single();
        sb.push_back('{cyc: cyc + 5, pc: exp_pc, instr: mem[exp_pc],
                       operand: 8'h00, two_byte: 1'b0});
    endtask

    // Runs one instruction cycle from just after the edge entering A1 to
    // just after the edge entering the next A1. jump/hold are presented in
    // X3 only; with noise set, both are also asserted through A1..X2.
    // honoured=0 marks a cycle where the DUT must ignore jump/hold.
    task automatic instr_cycle(input bit jmp, input logic [7:0] jaddr, input bit hld,
                               input bit noise, input bit honoured);
        if (noise) begin
            jump_en   = 1'b1;
            hold      = 1'b1;
            jump_addr = 8'h77;
        end
        @(negedge clock);
        check("pc_at_a1", pc, exp_pc);
        check("bus_a1", {4'h0, data}, {4'h0, exp_pc[3:0]});
        @(posedge clock); #1;
        @(negedge clock);
        check("bus_a2", {4'h0, data}, {4'h0, exp_pc[7:4]});
        @(posedge clock); #1;
        @(negedge clock);
        check("bus_a3_released", {4'h0, data}, 8'h0F);
        check("sync_a3", {7'd0, sync}, 8'h00);
        repeat (5) @(posedge clock);
        #1;
        jump_en   = jmp;
        hold      = hld;
        jump_addr = jaddr;
        @(negedge clock);
        check("sync_x3", {7'd0, sync}, 8'h01);
        @(posedge clock); #1;
        jump_en   = 1'b0;
        hold      = 1'b0;
        jump_addr = 8'h00;
        if (honoured && jmp)      exp_pc = jaddr;
        else if (honoured && hld) exp_pc = exp_pc;
        else                      exp_pc = exp_pc + 8'd1;
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        logic [7:0] t;
        reset_n   = 1'b0;
        jump_en   = 1'b0;
        hold      = 1'b0;
        jump_addr = 8'h00;
        exp_pc    = 8'h00;
        // All single-byte opcodes (high nibble 8..F) unless placed later.
        for (int i = 0; i < 256; i++) begin
            t      = 8'(i * 7);
            mem[i] = {1'b1, t[6:0]};
        end
        mem[0] = 8'hD5;

        // Reset state, with the counter held while reset is low.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_pc",       pc,                  8'h00);
        check("rst_instr",    instr,               8'h00);
        check("rst_operand",  operand,             8'h00);
        check("rst_valid",    {7'd0, instr_valid}, 8'h00);
        check("rst_two_byte", {7'd0, two_byte},    8'h00);
        check("rst_sync",     {7'd0, sync},        8'h00);
        check("rst_bus",      {4'h0, data},        8'h0F);

        // Release: first A1 fetches 0x00 (0xD5), valid in clock 5.
        @(posedge clock); #1;
        reset_n = 1'b1;
        push_single();
        instr_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // pc 0x01; jump to 0x3C with hold also set: jump wins.
        push_single();
        instr_cycle(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);

        // At 0x3C (bus shows 0xC then 0x3); jump to 0x10.
        push_single();
        instr_cycle(1'b1, 8'h10, 1'b0, 1'b0, 1'b1);

        // Hold at 0x10, with jump noise outside X3: 0x10 refetched.
        push_single();
        instr_cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        push_single();
        instr_cycle(1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);

        // Free run from 0xFE across the 0xFF -> 0x00 wrap.
        for (int i = 0; i < 256; i++) begin
            push_single();
            instr_cycle(1'b0, 8'h00, 1'b0, (i % 16) == 3, 1'b1);
        end

`ifdef FETCH_TWO_BYTE_EN
        // 0x40 0xA7 at 0x20/0x21: jump in the first X3 is ignored, the
        // instruction completes 13 clocks after its first A1.
        mem[8'h20] = 8'h40;
        mem[8'h21] = 8'hA7;
        push_single();
        instr_cycle(1'b1, 8'h20, 1'b0, 1'b0, 1'b1);
        sb.push_back('{cyc: cyc + 13, pc: 8'h21, instr: 8'h40,
                       operand: 8'hA7, two_byte: 1'b1});
        instr_cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        instr_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        push_single();
        instr_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
`endif

        // Reset in the middle of M1 while the ROM is driving.
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_bus",      {4'h0, data},        8'h0F);
        check("midrst_pc",       pc,                  8'h00);
        check("midrst_instr",    instr,               8'h00);
        check("midrst_operand",  operand,             8'h00);
        check("midrst_valid",    {7'd0, instr_valid}, 8'h00);
        check("midrst_two_byte", {7'd0, two_byte},    8'h00);
        check("midrst_sync",     {7'd0, sync},        8'h00);
        sb.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        exp_pc  = 8'h00;
        push_single();
        instr_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        push_single();
        instr_cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        check("scoreboard_drained", 8'(sb.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_unit
